// File: rtl/osc_readout_pkg.sv
// Shared types and defaults for the ring-oscillator readout path.
// Used by osc_sample_writer (optional feature macro: WRITER_WRAP_EN).
package osc_readout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int OSC_SEL_W   = 5;
  localparam int CNT_W_DEF   = 24;
  localparam int ROUND_W_DEF = 6;
  localparam int MAX_OSC     = 32;

endpackage

// File: rtl/osc_sample_writer.sv
// Captures the selected oscillator count on each sample strobe and writes it to result SRAM.
// Define WRITER_WRAP_EN to wrap the round index (ring-buffer logging) instead of stopping in DONE.
module osc_sample_writer
  import osc_readout_pkg::*;
#(
  parameter int NumOsc     = 10,
  parameter int CntWidth   = CNT_W_DEF,
  parameter int RoundWidth = ROUND_W_DEF
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [OSC_SEL_W-1:0]            OscSel_i,
  input  logic                            Sample_i,
  input  logic                            Resetn_i,
  input  logic [CntWidth-1:0]             OscCnt_i,
  input  logic                            Clear_i,
  input  logic                            MemReady_i,
  output logic                            MemWe_o,
  output logic [RoundWidth+OSC_SEL_W-1:0] MemAddr_o,
  output logic [CntWidth-1:0]             MemWdata_o,
  output logic [RoundWidth-1:0]           Round_o,
  output logic                            Done_o,
  output logic                            Overrun_o,
  output logic                            SelErr_o,
  output logic                            SeqErr_o
);

  localparam logic [OSC_SEL_W:0]   NUM_OSC_EXT = (OSC_SEL_W + 1)'(NumOsc);
  localparam logic [OSC_SEL_W-1:0] LAST_SEL    = OSC_SEL_W'(NumOsc - 1);

  state_e                 state_reg, state_next;
  logic [CntWidth-1:0]    data_reg, data_next;
  logic [OSC_SEL_W-1:0]   sel_reg, sel_next;
  logic [OSC_SEL_W-1:0]   exp_sel_reg, exp_sel_next;
  logic [RoundWidth-1:0]  round_reg, round_next;
  logic                   overrun_reg, overrun_next;
  logic                   sel_err_reg, sel_err_next;
  logic                   seq_err_reg, seq_err_next;

  logic sel_ok;
  logic commit;

  assign sel_ok = ({1'b0, OscSel_i} < NUM_OSC_EXT);
  assign commit = (state_reg == WRITE) && MemReady_i;

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    sel_next     = sel_reg;
    exp_sel_next = exp_sel_reg;
    round_next   = round_reg;
    overrun_next = overrun_reg;
    sel_err_next = sel_err_reg;
    seq_err_next = seq_err_reg;

    unique case (state_reg)
      IDLE: begin
        if (Sample_i) begin
          if (!Resetn_i) begin
            seq_err_next = 1'b1;
          end
          if (!sel_ok) begin
            sel_err_next = 1'b1;
          end
          if (Resetn_i && sel_ok) begin
            data_next  = OscCnt_i;
            sel_next   = OscSel_i;
            state_next = WRITE;
            if (OscSel_i != exp_sel_reg) begin
              seq_err_next = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        if (Sample_i) begin
          overrun_next = 1'b1;
        end
        if (commit) begin
          state_next   = IDLE;
          exp_sel_next = (sel_reg == LAST_SEL) ? '0 : sel_reg + 1'b1;
          if (sel_reg == LAST_SEL) begin
            if (round_reg == '1) begin
`ifdef WRITER_WRAP_EN
              round_next = '0;
`else
              state_next = DONE;
`endif
            end else begin
              round_next = round_reg + 1'b1;
            end
          end
        end
      end
      DONE: begin
        // Terminal until cleared; strobes are silently ignored here.
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase

    // Clear wins over everything, including a commit in the same cycle.
    if (Clear_i) begin
      state_next   = IDLE;
      exp_sel_next = '0;
      round_next   = '0;
      overrun_next = 1'b0;
      sel_err_next = 1'b0;
      seq_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      sel_reg     <= '0;
      exp_sel_reg <= '0;
      round_reg   <= '0;
      overrun_reg <= 1'b0;
      sel_err_reg <= 1'b0;
      seq_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      sel_reg     <= sel_next;
      exp_sel_reg <= exp_sel_next;
      round_reg   <= round_next;
      overrun_reg <= overrun_next;
      sel_err_reg <= sel_err_next;
      seq_err_reg <= seq_err_next;
    end
  end

  assign MemWe_o    = (state_reg == WRITE);
  assign MemAddr_o  = {round_reg, sel_reg};
  assign MemWdata_o = data_reg;
  assign Round_o    = round_reg;
  assign Done_o     = (state_reg == DONE);
  assign Overrun_o  = overrun_reg;
  assign SelErr_o   = sel_err_reg;
  assign SeqErr_o   = seq_err_reg;

endmodule

// File: tb/tb_osc_sample_writer.sv
// Scoreboard bench for osc_sample_writer (NumOsc=10, RoundWidth=2); honours WRITER_WRAP_EN.
module tb_osc_sample_writer;

  localparam int AW = 7;
  localparam int CW = 24;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [4:0]    OscSel_i = '0;
  logic          Sample_i = 1'b0;
  logic          Resetn_i = 1'b1;
  logic [CW-1:0] OscCnt_i = '0;
  logic          Clear_i = 1'b0;
  logic          MemReady_i = 1'b1;
  logic          MemWe_o;
  logic [AW-1:0] MemAddr_o;
  logic [CW-1:0] MemWdata_o;
  logic [1:0]    Round_o;
  logic          Done_o, Overrun_o, SelErr_o, SeqErr_o;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  wr_t exp_q[$];

  osc_sample_writer #(.NumOsc(10), .CntWidth(CW), .RoundWidth(2)) dut (
    .clk(clk), .rstn(rstn), .OscSel_i(OscSel_i), .Sample_i(Sample_i),
    .Resetn_i(Resetn_i), .OscCnt_i(OscCnt_i), .Clear_i(Clear_i),
    .MemReady_i(MemReady_i), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o),
    .MemWdata_o(MemWdata_o), .Round_o(Round_o), .Done_o(Done_o),
    .Overrun_o(Overrun_o), .SelErr_o(SelErr_o), .SeqErr_o(SeqErr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic push(input int addr, input int data);
    wr_t w;
    w.addr = AW'(addr);
    w.data = CW'(data);
    exp_q.push_back(w);
  endtask

  // Monitor: every committed write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && MemWe_o && MemReady_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(MemAddr_o), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("write_addr", 32'(MemAddr_o), 32'(w.addr));
        chk("write_data", 32'(MemWdata_o), 32'(w.data));
        $display("write addr=0x%02h data=0x%06h", MemAddr_o, MemWdata_o);
      end
    end
  end

  task automatic strobe(input logic [4:0] sel, input logic [CW-1:0] cnt, input logic rn);
    @(posedge clk); #1;
    Sample_i = 1'b1; OscSel_i = sel; OscCnt_i = cnt; Resetn_i = rn;
    @(posedge clk); #1;
    Sample_i = 1'b0; Resetn_i = 1'b1;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1; Clear_i = 1'b1;
    @(posedge clk); #1; Clear_i = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(MemWe_o), 0);
    chk("rst_addr", 32'(MemAddr_o), 0);
    chk("rst_data", 32'(MemWdata_o), 0);
    chk("rst_round", 32'(Round_o), 0);
    chk("rst_flags", {28'd0, Done_o, Overrun_o, SelErr_o, SeqErr_o}, 0);
    rstn = 1'b1;

    // One full round, SRAM always ready.
    for (int s = 0; s < 10; s++) begin
      push(s, 'h100 + s);
      strobe(5'(s), CW'('h100 + s), 1'b1);
    end
    settle();
    chk("round_after_r0", 32'(Round_o), 1);
    chk("flags_after_r0", {28'd0, Done_o, Overrun_o, SelErr_o, SeqErr_o}, 0);

    // Backpressure: five stalled cycles then commit on the sixth.
    MemReady_i = 1'b0;
    push(32, 'hABC);
    strobe(5'd0, 24'hABC, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_we", 32'(MemWe_o), 1);
      chk("stall_addr", 32'(MemAddr_o), 32);
      chk("stall_data", 32'(MemWdata_o), 'hABC);
      if (i == 4) begin
        @(posedge clk); #1; MemReady_i = 1'b1;
      end
    end
    @(negedge clk);
    chk("stall_we_drop", 32'(MemWe_o), 0);

    // Overrun: strobe in the cycle the write commits.
    push(33, 'h201);
    strobe(5'd1, 24'h201, 1'b1);
    Sample_i = 1'b1; OscSel_i = 5'd2; OscCnt_i = 24'h999;
    @(posedge clk); #1; Sample_i = 1'b0;
    @(negedge clk);
    chk("overrun_set", 32'(Overrun_o), 1);
    chk("overrun_no_seq", 32'(SeqErr_o), 0);
    settle();
    chk("overrun_idle_we", 32'(MemWe_o), 0);

    clear_pulse();
    @(negedge clk);
    chk("clear_round", 32'(Round_o), 0);
    chk("clear_flags", {28'd0, Done_o, Overrun_o, SelErr_o, SeqErr_o}, 0);

    // Out-of-range select, then out-of-order select.
    strobe(5'd12, 24'h0C0, 1'b1);
    @(negedge clk);
    chk("selerr_set", 32'(SelErr_o), 1);
    chk("selerr_no_write", 32'(MemWe_o), 0);
    chk("selerr_no_seq", 32'(SeqErr_o), 0);
    push(3, 'h333);
    strobe(5'd3, 24'h333, 1'b1);
    settle();
    chk("seqerr_set", 32'(SeqErr_o), 1);

    // Strobe during counter-clear window is dropped and flagged.
    clear_pulse();
    strobe(5'd0, 24'h444, 1'b0);
    @(negedge clk);
    chk("window_seqerr", 32'(SeqErr_o), 1);
    chk("window_no_write", 32'(MemWe_o), 0);

    // Four full rounds fill the 2-bit round space.
    clear_pulse();
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 10; s++) begin
        push(r * 32 + s, 'h500 + r * 16 + s);
        strobe(5'(s), CW'('h500 + r * 16 + s), 1'b1);
      end
    end
    settle();
`ifdef WRITER_WRAP_EN
    chk("full_done", 32'(Done_o), 0);
    chk("full_round_wrap", 32'(Round_o), 0);
    push(0, 'hEEE);
`else
    chk("full_done", 32'(Done_o), 1);
`endif
    strobe(5'd0, 24'hEEE, 1'b1);
    settle();
    chk("full_no_flags", {29'd0, Overrun_o, SelErr_o, SeqErr_o}, 0);
    clear_pulse();
    @(negedge clk);
    chk("clear_done", 32'(Done_o), 0);
    chk("clear_round2", 32'(Round_o), 0);

    // Asynchronous reset while a write is pending.
    MemReady_i = 1'b0;
    strobe(5'd4, 24'h4A4, 1'b1);
    @(negedge clk);
    chk("pre_rst_we", 32'(MemWe_o), 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_we", 32'(MemWe_o), 0);
    chk("async_rst_addr", 32'(MemAddr_o), 0);
    @(negedge clk); #2 rstn = 1'b1;
    MemReady_i = 1'b1;
    push(0, 'h777);
    strobe(5'd0, 24'h777, 1'b1);
    settle();
    chk("post_rst_seq", 32'(SeqErr_o), 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
